mul_seq32: RTL and testbench

Sequential 32x32 shift-add multiplier controller that drives the combinational 32-bit add/subtract unit. It sits on both sides of the arithmetic unit in the ALU datapath. It feeds the unit's operands and function select (`alu_a`, `alu_b`, `alu_f0`, `alu_f1`) and consumes the sum and carry (`alu_s`, `alu_c`). It accumulates a 64-bit product over 32 iterations. Because the ripple-carry unit is slow, a settle counter holds the unit's inputs stable for a programmable number of cycles before each result is captured.

---
 rtl/mul_seq32.sv | 167 ++++++++++++++++
 tb/tb_mul_seq32.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq32.sv
// mul_seq32: sequential 32x32 shift-add multiplier that sequences an external
// combinational 32-bit add/subtract unit, waiting SETTLE_CYCLES per add.
// Optional feature: define MUL_SIGNED_EN for two's-complement operands.
module mul_seq32 #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] mcand,
   input  logic [31:0] mplier,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_f0,
   output logic        alu_f1,
   input  logic [31:0] alu_s,
   input  logic        alu_c
);

`ifdef MUL_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nxt;

   logic [31:0]     hi, lo, mc;
   logic [5:0]      it;
   logic [SC_W-1:0] sc;

   logic [31:0]     hi_n, lo_n, mc_n;
   logic [5:0]      it_n;
   logic [SC_W-1:0] sc_n;
   logic            s_in;
   logic [31:0]     b_eff;
   logic            step;

   logic            busy_n, done_n, alu_f0_n;
   logic [63:0]     product_n;
   logic [31:0]     alu_a_n, alu_b_n;

   // An iteration finishes on a no-add cycle or on the last cycle of a settle window
   assign step = (state == CALC) && (!lo[0] || (sc == SC_LAST));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (step && (it == 6'd31)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath next values: operand capture and the shift/accumulate step
   always_comb begin
      hi_n  = hi;
      lo_n  = lo;
      mc_n  = mc;
      it_n  = it;
      sc_n  = sc;
      s_in  = 1'b0;
      b_eff = alu_f0 ? ~mc : mc;
      case (state)
         IDLE: begin
            if (start) begin
               mc_n = mcand;
               lo_n = mplier;
               hi_n = 32'd0;
               it_n = 6'd0;
               sc_n = '0;
            end
         end
         CALC: begin
            if (lo[0]) begin
               if (sc == SC_LAST) begin
                  // 33-bit sum sign: sign of A xor sign of effective B xor carry
                  s_in = SIGNED_EN ? (hi[31] ^ b_eff[31] ^ alu_c) : alu_c;
                  hi_n = {s_in, alu_s[31:1]};
                  lo_n = {alu_s[0], lo[31:1]};
                  it_n = it + 6'd1;
                  sc_n = '0;
               end else begin
                  sc_n = sc + SC_W'(1);
               end
            end else begin
               s_in = SIGNED_EN ? hi[31] : 1'b0;
               hi_n = {s_in, hi[31:1]};
               lo_n = {hi[0], lo[31:1]};
               it_n = it + 6'd1;
            end
         end
         default: ;
      endcase
   end

   // Output next values; adder inputs are loaded only at iteration boundaries
   always_comb begin
      busy_n    = (state_nxt != IDLE);
      done_n    = (state == CALC) && (state_nxt == DONE);
      product_n = done_n ? {hi_n, lo_n} : product;
      alu_a_n   = 32'd0;
      alu_b_n   = 32'd0;
      alu_f0_n  = 1'b0;
      if (state_nxt == CALC) begin
         if ((state != CALC) || step) begin
            if (lo_n[0]) begin
               alu_a_n  = hi_n;
               alu_b_n  = mc_n;
               alu_f0_n = SIGNED_EN && (it_n == 6'd31);
            end
         end else begin
            alu_a_n  = alu_a;
            alu_b_n  = alu_b;
            alu_f0_n = alu_f0;
         end
      end
   end

   // Register datapath and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         hi      <= 32'd0;
         lo      <= 32'd0;
         mc      <= 32'd0;
         it      <= 6'd0;
         sc      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= 64'd0;
         alu_a   <= 32'd0;
         alu_b   <= 32'd0;
         alu_f0  <= 1'b0;
         alu_f1  <= 1'b0;
      end else begin
         hi      <= hi_n;
         lo      <= lo_n;
         mc      <= mc_n;
         it      <= it_n;
         sc      <= sc_n;
         busy    <= busy_n;
         done    <= done_n;
         product <= product_n;
         alu_a   <= alu_a_n;
         alu_b   <= alu_b_n;
         alu_f0  <= alu_f0_n;
         alu_f1  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_seq32.sv
// tb_mul_seq32: table-driven bench for mul_seq32 with a behavioural
// add/subtract unit and a queue of expected results.
module tb_mul_seq32;

`ifdef MUL_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   localparam int unsigned S = 2;

   logic        clk, rst, start;
   logic [31:0] mcand, mplier;
   logic        busy, done;
   logic [63:0] product;
   logic [31:0] alu_a, alu_b, alu_s;
   logic        alu_f0, alu_f1, alu_c;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      bit          spam;
   } vec_t;

   typedef struct {
      logic [63:0] prod;
      int          lat;
      bit          sub;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   mul_seq32 #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f0(alu_f0), .alu_f1(alu_f1),
      .alu_s(alu_s), .alu_c(alu_c)
   );

   // Behavioural arithmetic unit: 00 add, 10 subtract (A + ~B + 1)
   logic [32:0] alu_res;
   always_comb begin
      if (alu_f0 && !alu_f1) alu_res = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      else                   alu_res = {1'b0, alu_a} + {1'b0, alu_b};
   end
   assign alu_s = alu_res[31:0];
   assign alu_c = alu_res[32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      if (SIGNED_EN) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input bit spam);
      exp_t e;
      int   n;
      bit   saw_sub, alu_nz;
      e.prod = p;
      e.lat  = 32 + $countones(b) * (S - 1) + 1;
      e.sub  = SIGNED_EN && b[31];
      exp_q.push_back(e);
      saw_sub = 1'b0;
      alu_nz  = 1'b0;
      @(negedge clk);
      mcand = a; mplier = b; start = 1'b1;
      @(posedge clk); #1;
      n = 1;
      check("busy_after_accept", 64'(busy), 64'd1);
      if (alu_f0) saw_sub = 1'b1;
      if (alu_a != 0 || alu_b != 0) alu_nz = 1'b1;
      while (!done && n < 400) begin
         @(negedge clk);
         if (spam) begin
            start = 1'b1; mcand = $urandom; mplier = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (alu_f0) saw_sub = 1'b1;
         if (alu_a != 0 || alu_b != 0) alu_nz = 1'b1;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL done_timeout: no done after %0d cycles", n);
      end
      e = exp_q.pop_front();
      check("product", product, e.prod);
      check("latency", 64'(n), 64'(e.lat));
      check("subtract_seen", 64'(saw_sub), 64'(e.sub));
      if (b == 32'd0) check("alu_idle_zero_mplier", 64'(alu_nz), 64'd0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("done_busy_drop", {62'd0, done, busy}, 64'd0);
      check("product_hold", product, e.prod);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;

      if (SIGNED_EN) begin
         vecs.push_back('{32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
         vecs.push_back('{32'd7,         32'h8000_0000, 64'hFFFF_FFFC_8000_0000, 1'b0});
         vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                   1'b0});
      end else begin
         vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0});
         vecs.push_back('{32'd7,         32'h8000_0000, 64'h0000_0003_8000_0000, 1'b0});
      end
      vecs.push_back('{32'd30,   32'd7, 64'h0000_0000_0000_00D2, 1'b0});
      vecs.push_back('{32'd1234, 32'd0, 64'd0,                   1'b0});
      vecs.push_back('{32'd1000, 32'd1000, 64'd1000000,          1'b1});
      for (int i = 0; i < 3; i++) begin
         v.a = $urandom; v.b = $urandom; v.p = ref_mul(v.a, v.b); v.spam = 1'b0;
         vecs.push_back(v);
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {62'd0, busy, done}, 64'd0);
      check("reset_product", product, 64'd0);
      check("reset_alu", {alu_a, alu_b[29:0], alu_f0, alu_f1}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) do_mul(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].spam);

      // Abort mid-multiply, then a clean multiply must behave normally
      @(negedge clk);
      mcand = 32'hFFFF_FFFF; mplier = 32'h0000_FFFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_ctrl", {62'd0, busy, done}, 64'd0);
      check("abort_product", product, 64'd0);
      check("abort_alu", {alu_a, alu_b[29:0], alu_f0, alu_f1}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_mul(32'd5, 32'd6, 64'd30, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
